// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the serial FIR filter:
//   - fir_state_e : FSM state encodings (IDLE / MAC / DONE)
//   - clog2()     : elaboration-time ceil(log2(n)), minimum result 1
//   - acc_width() : full-precision accumulator width for a given configuration
// No ports (package).
// -----------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    // Returns at least 1 so that an index for a 1- or 2-entry array still
    // has a legal width.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Product of two signed operands plus growth for summing num_taps terms.
    function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
        return data_w + coef_w + clog2(num_taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Single signed multiply-accumulate unit with a registered accumulator.
// Each enabled cycle adds sample*coef (sign-extended, full precision) to acc.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   acc_clr   : clear accumulator to zero (takes priority over acc_en)
//   acc_en    : add the current product into the accumulator
//   sample    : signed data operand  [DATA_WIDTH]
//   coef      : signed coefficient   [COEF_WIDTH]
//   acc       : accumulator value    [ACC_WIDTH]
// -----------------------------------------------------------------------------
module fir_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 35
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         acc_clr,
    input  logic                         acc_en,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;

    always_comb begin
        prod     = sample * coef;
        prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
        acc_d    = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_serial_filter.sv
// -----------------------------------------------------------------------------
// fir_serial_filter
// Time-multiplexed single-MAC FIR filter: y[n] = sum_k h[k]*x[n-k].
// One sample is accepted per handshake, then NUM_TAPS MAC cycles and one
// DONE cycle follow; out_valid pulses for one cycle with the result.
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is high only in IDLE; while it is low the sample is not
// consumed and upstream must hold it. out_valid is a single-cycle pulse with
// no back-pressure; out_data holds until the next result.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input sample present
//   in_ready   : filter idle, sample accepted this cycle if in_valid
//   in_data    : signed input sample              [DATA_WIDTH]
//   coef_we    : coefficient write strobe (honoured only in IDLE)
//   coef_addr  : tap index k                      [clog2(NUM_TAPS)]
//   coef_data  : signed coefficient h[k]          [COEF_WIDTH]
//   out_valid  : one-cycle result strobe
//   out_data   : signed filtered sample           [OUT_WIDTH]
//
// Configuration macro FIR_SAT_EN: when defined, out_data saturates to the
// signed OUT_WIDTH range instead of wrapping.
// -----------------------------------------------------------------------------
module fir_serial_filter
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         coef_we,
    input  logic [clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic [COEF_WIDTH-1:0]        coef_data,
    output logic                         out_valid,
    output logic [OUT_WIDTH-1:0]         out_data
);

    localparam int IDX_W     = clog2(NUM_TAPS);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
    localparam int EXT_W     = ACC_WIDTH + OUT_SHIFT + OUT_WIDTH;

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W:0]   TAPS_EXT = (IDX_W + 1)'(NUM_TAPS);

    fir_state_e state_q, state_d;
    logic [IDX_W-1:0]      k_q, k_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] delay_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] delay_d [NUM_TAPS];
    logic [COEF_WIDTH-1:0] coef_q  [NUM_TAPS];
    logic [COEF_WIDTH-1:0] coef_d  [NUM_TAPS];
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic                        acc_clr;
    logic                        acc_en;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [IDX_W:0]              tap_sum;
    logic [IDX_W-1:0]            tap_idx;
    logic signed [EXT_W-1:0]     acc_ext;
    logic [OUT_WIDTH-1:0]        out_slice;

    // ------------------------------------------------------------------
    // Delay-line read index: (wr_ptr - k) mod NUM_TAPS without a divider.
    // Adding NUM_TAPS first keeps the intermediate non-negative; one
    // conditional subtract brings it back into range.
    // ------------------------------------------------------------------
    always_comb begin
        tap_sum = {1'b0, wr_ptr_q} + TAPS_EXT - {1'b0, k_q};
        if (tap_sum >= TAPS_EXT) begin
            tap_sum = tap_sum - TAPS_EXT;
        end
    end

    assign tap_idx = tap_sum[IDX_W-1:0];

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .sample  (delay_q[tap_idx]),
        .coef    (coef_q[k_q]),
        .acc     (acc)
    );

    // ------------------------------------------------------------------
    // Output slice. The accumulator is sign-extended far enough that any
    // OUT_SHIFT/OUT_WIDTH window is a legal part-select.
    // ------------------------------------------------------------------
    assign acc_ext = {{(OUT_SHIFT + OUT_WIDTH){acc[ACC_WIDTH-1]}}, acc};

`ifdef FIR_SAT_EN
    logic signed [EXT_W-1:0] acc_shr;
    logic signed [EXT_W-1:0] sat_max;
    logic signed [EXT_W-1:0] sat_min;

    always_comb begin
        acc_shr = acc_ext >>> OUT_SHIFT;
        sat_max = {{(EXT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
        sat_min = ~sat_max;
        if (acc_shr > sat_max) begin
            out_slice = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (acc_shr < sat_min) begin
            out_slice = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            out_slice = acc_shr[OUT_WIDTH-1:0];
        end
    end
`else
    assign out_slice = acc_ext[OUT_SHIFT +: OUT_WIDTH];
`endif

    // ------------------------------------------------------------------
    // FSM next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        delay_d     = delay_q;
        coef_d      = coef_q;

        unique case (state_q)
            ST_IDLE: begin
                // A coefficient write in the same cycle as an accept lands
                // before the first MAC cycle, so that sample already uses it.
                if (coef_we && (int'(coef_addr) < NUM_TAPS)) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (in_valid) begin
                    delay_d[wr_ptr_q] = in_data;
                    acc_clr           = 1'b1;
                    k_d               = '0;
                    state_d           = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_en = 1'b1;
                if (k_q == LAST_TAP) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                out_data_d  = out_slice;
                out_valid_d = 1'b1;
                wr_ptr_d    = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            delay_q     <= delay_d;
            coef_q      <= coef_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_serial_filter.sv
// -----------------------------------------------------------------------------
// tb_fir_serial_filter
// Directed bench for fir_serial_filter with NUM_TAPS=4. Two instances share
// every input: u_dut (OUT_WIDTH=32) for the main function and u_dut_w16
// (OUT_WIDTH=16) for the overflow behaviour selected by FIR_SAT_EN.
// -----------------------------------------------------------------------------
module tb_fir_serial_filter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        in_ready_w16;
    logic        out_valid_w16;
    logic [15:0] out_data_w16;

    int tests_run;
    int tests_failed;

    fir_serial_filter #(
        .DATA_WIDTH (16),
        .COEF_WIDTH (16),
        .NUM_TAPS   (4),
        .OUT_WIDTH  (32),
        .OUT_SHIFT  (0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    fir_serial_filter #(
        .DATA_WIDTH (16),
        .COEF_WIDTH (16),
        .NUM_TAPS   (4),
        .OUT_WIDTH  (16),
        .OUT_SHIFT  (0)
    ) u_dut_w16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w16),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid_w16),
        .out_data  (out_data_w16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic write_coef(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    // Presents a sample and holds it until accepted; returns 1 ns after the
    // accept edge.
    task automatic send(input logic [15:0] x);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the accept cycle (0) to the out_valid cycle.
    task automatic wait_out(output int cycles, output bit seen);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        cycles = n;
        seen   = out_valid;
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL out_timeout: out_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        tests_run++;
        if (out_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %0d required 0", out_data);
        end
        tests_run++;
        if (out_data_w16 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_out_data_w16: got %0d required 0", out_data_w16);
        end
    endtask

    task automatic load_ramp_coefs();
        write_coef(2'd0, 16'd1);
        write_coef(2'd1, 16'd2);
        write_coef(2'd2, 16'd3);
        write_coef(2'd3, 16'd4);
    endtask

    task automatic test_impulse();
        logic [15:0] xs  [5] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [31:0] exp [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        int  cyc;
        bit  seen;
        load_ramp_coefs();
        for (int i = 0; i < 5; i++) begin
            send(xs[i]);
            wait_out(cyc, seen);
            tests_run++;
            if (out_data !== exp[i]) begin
                tests_failed++;
                $display("FAIL impulse_%0d: got %0d required %0d", i, $signed(out_data), exp[i]);
            end
            if (i == 0) begin
                @(negedge clk);
                tests_run++;
                if (out_valid !== 1'b0 || out_data !== 32'd1) begin
                    tests_failed++;
                    $display("FAIL impulse_pulse_width: out_valid=%0b out_data=%0d required 0 and 1",
                             out_valid, out_data);
                end
            end
        end
    endtask

    task automatic test_step();
        logic [31:0] exp [5] = '{32'd5, 32'd15, 32'd30, 32'd50, 32'd50};
        int  cyc;
        bit  seen;
        for (int i = 0; i < 5; i++) begin
            send(16'd5);
            wait_out(cyc, seen);
            tests_run++;
            if (out_data !== exp[i]) begin
                tests_failed++;
                $display("FAIL step_%0d: got %0d required %0d", i, $signed(out_data), exp[i]);
            end
            if (i == 0) begin
                tests_run++;
                if (cyc != 6) begin
                    tests_failed++;
                    $display("FAIL step_latency: got %0d cycles required 6", cyc);
                end
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL step_ready_with_valid: in_ready=%0b required 1", in_ready);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3] = '{32'd46, 32'd39, 32'd30};
        int acc_cyc [3];
        int n_acc;
        int n_out;
        bit taken;
        n_acc = 0;
        n_out = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'd1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            taken = 1'b0;
            if (out_valid) begin
                tests_run++;
                if (n_out >= 3) begin
                    tests_failed++;
                    $display("FAIL bp_extra_out: got out_data=%0d, required no further output", out_data);
                end else if (out_data !== exp[n_out]) begin
                    tests_failed++;
                    $display("FAIL bp_out_%0d: got %0d required %0d", n_out, $signed(out_data), exp[n_out]);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (n_acc < 3) acc_cyc[n_acc] = c;
                n_acc++;
                taken = 1'b1;
            end
            @(posedge clk);
            #1;
            if (taken) begin
                if (n_acc < 3) in_data = 16'(n_acc + 1);
                else           in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (n_acc != 3 || n_out != 3) begin
            tests_failed++;
            $display("FAIL bp_counts: accepts=%0d outputs=%0d required 3 and 3", n_acc, n_out);
        end else begin
            tests_run++;
            if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
                tests_failed++;
                $display("FAIL bp_spacing: gaps %0d,%0d required 6,6",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    task automatic test_coef_write();
        int cyc;
        bit seen;
        // Write during MAC must be ignored: h stays [1,2,3,4].
        send(16'd1);
        write_coef(2'd0, 16'd9);
        wait_out(cyc, seen);
        tests_run++;
        if (out_data !== 32'd17) begin
            tests_failed++;
            $display("FAIL coef_busy_ignored: got %0d required 17", $signed(out_data));
        end
        // Same write while idle is used by the next sample: h = [9,2,3,4].
        write_coef(2'd0, 16'd9);
        send(16'd2);
        wait_out(cyc, seen);
        tests_run++;
        if (out_data !== 32'd37) begin
            tests_failed++;
            $display("FAIL coef_idle_applied: got %0d required 37", $signed(out_data));
        end
        // Write and accept in the same cycle: h = [9,0,3,4] for this sample.
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 16'd0;
        in_valid  = 1'b1;
        in_data   = 16'd1;
        @(posedge clk);
        #1;
        coef_we  = 1'b0;
        in_valid = 1'b0;
        wait_out(cyc, seen);
        tests_run++;
        if (out_data !== 32'd24) begin
            tests_failed++;
            $display("FAIL coef_same_cycle: got %0d required 24", $signed(out_data));
        end
    endtask

    task automatic test_reset_mid_mac();
        int pulses;
        int cyc;
        bit seen;
        send(16'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midmac_reset_state: out_valid=%0b out_data=%0d in_ready=%0b required 0,0,1",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL midmac_no_pulse: got %0d pulses required 0", pulses);
        end
        send(16'd1);
        wait_out(cyc, seen);
        tests_run++;
        if (out_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL midmac_coefs_cleared: got %0d required 0", $signed(out_data));
        end
    endtask

    task automatic test_overflow_w16();
        int cyc;
        bit seen;
        logic [15:0] exp [4];
`ifdef FIR_SAT_EN
        exp = '{16'd32767, 16'd32767, 16'd32767, 16'd32767};
`else
        // Sums are k*32767^2 = k*0x3FFF0001; the low 16 bits are k.
        exp = '{16'd1, 16'd2, 16'd3, 16'd4};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(2'(k), 16'd32767);
        for (int i = 0; i < 4; i++) begin
            send(16'd32767);
            wait_out(cyc, seen);
            tests_run++;
            if (out_data_w16 !== exp[i]) begin
                tests_failed++;
                $display("FAIL w16_overflow_%0d: got %0d required %0d", i, $signed(out_data_w16), exp[i]);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_impulse();
        test_step();
        test_back_to_back();
        test_coef_write();
        test_reset_mid_mac();
        test_overflow_w16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
